// File: rtl/imem_fetch_if.sv
// imem_fetch_if -- bus bundle between the fetch sequencer, instruction memory
// and decode.
//   imem_req/imem_addr/imem_rdata : one-cycle-latency instruction memory read
//   redirect_valid/redirect_pc    : pipeline redirect (flush + restart fetch)
//   out_valid/out_ready           : handshake toward decode
//   out_ins/out_pc                : instruction word and its byte address
// master: the fetch sequencer side. slave: the memory/decode/pipeline side.
interface imem_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_pc;

  modport master (
    output imem_req, imem_addr, out_valid, out_ins, out_pc,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_ins, out_pc,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl -- instruction-fetch sequencer.
// Owns the fetch PC, keeps at most one read outstanding to a synchronous
// instruction memory (one-cycle latency), buffers returned words in a
// DEPTH-entry circular queue and presents the head to decode over
// valid/ready. A redirect flushes the queue, drops the in-flight response
// and issues a read for the new PC in the same cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : imem_fetch_if.master (memory read port, redirect, decode handshake)
// Parameters: RESET_PC (word aligned), DEPTH (power of two, >= 2).
// Optional macro FETCH_TRACE_EN: prints one line per queue push and per
// redirect in simulation; no effect on logic.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_fetch_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 2;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } fq_entry_t;

  logic [31:0]   r_pc;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  fq_entry_t     r_q [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_redir;
  logic          w_pop;
  logic          w_push;
  logic          w_req;
  logic [31:0]   w_addr;
  logic [CW-1:0] w_credit;
  logic [1:0]    w_unused_lsb;

  assign w_unused_lsb = bus.redirect_pc[1:0];

  // Gated by rst_n so the memory sees no strobe while reset is held.
  assign w_redir  = rst_n & bus.redirect_valid;
  assign w_pop    = (r_count != '0) & bus.out_ready;
  // A response landing in a redirect cycle belongs to the old stream.
  assign w_push   = r_inflight & ~w_redir;
  // Slots already spoken for: queued words plus the outstanding read, minus
  // the one decode takes this cycle. Issuing only below DEPTH keeps every
  // push inside the queue.
  assign w_credit = r_count + CW'(r_inflight) - CW'(w_pop);
  assign w_req    = w_redir | (rst_n & (w_credit < CW'(DEPTH)));
  assign w_addr   = w_redir ? {bus.redirect_pc[31:2], 2'b00} : r_pc;

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = w_addr;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_ins   = r_q[r_rd_ptr].ins;
  assign bus.out_pc    = r_q[r_rd_ptr].pc;

  // Issue side: PC and the single outstanding-read tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_pc          <= w_addr + 32'd4;
        r_inflight_pc <= w_addr;
      end
    end
  end

  // Queue side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_q[r_wr_ptr] <= '{ins: bus.imem_rdata, pc: r_inflight_pc};
      if (w_redir) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Credit accounting makes this unreachable; firing means the issue rule broke.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(w_push && !w_pop && r_count == CW'(DEPTH)))
        else $error("fetch queue overflow");
    end
  end

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst_n && w_push) $display("fetch pc=%08x ins=%08x", r_inflight_pc, bus.imem_rdata);
    if (w_redir)         $display("redirect pc=%08x", {bus.redirect_pc[31:2], 2'b00});
  end
`else
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized bench for imem_fetch_ctrl. The reference is the delivered
// instruction stream: after reset or a redirect, decode must see consecutive
// word addresses from the restart PC, each carrying the memory word at that
// address, with fixed restart latency and bounded buffering under stall.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic clk;
  logic rst_n;
  imem_fetch_if bus ();

  imem_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous instruction memory; junk on the bus when no read was issued.
  always @(posedge clk) bus.imem_rdata <= bus.imem_req ? memf(bus.imem_addr) : $urandom;

  int nvec, nerr;
  int cyc, dl, fl, stall, hs;
  logic [31:0] exp_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %08x want %08x (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Restart model after a reset release.
  task automatic model_reset();
    cyc = 0; dl = 2; fl = -1; stall = 0;
    exp_pc = RESET_PC;
  endtask

  // Assert reset at a falling edge, check the asynchronous reset state,
  // release just after the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    chk("rst_req",  bus.imem_req,  0);
    chk("rst_addr", bus.imem_addr, RESET_PC);
    chk("rst_vld",  bus.out_valid, 0);
    chk("rst_ins",  bus.out_ins,   0);
    chk("rst_pc",   bus.out_pc,    0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle: drive inputs after the falling edge, check, then account for
  // what the next rising edge does to the expected stream.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic pop;
    @(negedge clk);
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
    if (cyc == dl) begin
      chk("lat_vld", bus.out_valid, 1);
      dl = -1;
    end
    if (cyc == fl) chk("flush_vld", bus.out_valid, 0);
    if (bus.out_valid) begin
      chk("out_pc",  bus.out_pc,  exp_pc);
      chk("out_ins", bus.out_ins, memf(exp_pc));
    end
    if (bus.imem_req) chk("align", bus.imem_addr[1:0], 0);
    if (rv) begin
      chk("rd_req",  bus.imem_req,  1);
      chk("rd_addr", bus.imem_addr, {rpc[31:2], 2'b00});
    end else if (stall >= 3) begin
      // Long stall: queue full, no fetch; on release fetch resumes at once.
      chk("bp_req", bus.imem_req,  rdy ? 1 : 0);
      chk("bp_vld", bus.out_valid, 1);
    end
    pop = bus.out_valid && rdy;
    if (pop) begin
      exp_pc = exp_pc + 32'd4;
      hs++;
    end
    if (rv) begin
      exp_pc = {rpc[31:2], 2'b00};
      dl = cyc + 2;
      fl = cyc + 1;
      stall = 0;
    end else if (!rdy) stall++;
    else stall = 0;
    cyc++;
  endtask

  initial begin
    nvec = 0; nerr = 0; hs = 0;
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Straight-line fetch with decode always ready.
    hs = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("addr_seq", bus.imem_addr, RESET_PC + 32'(4 * k));
    end
    chk("thruput", hs, 18);

    // Stall mid-stream, then release.
    repeat (5) step(1'b0, 1'b0, 32'h0);
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Redirect while the queue fills with a read outstanding; unaligned target.
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_3103);
    repeat (5) step(1'b1, 1'b0, 32'h0);

    // Redirect together with a pop, then a second redirect the next cycle.
    step(1'b1, 1'b1, 32'h0000_3400);
    step(1'b1, 1'b1, 32'h0000_3200);
    repeat (5) step(1'b1, 1'b0, 32'h0);

    // Address wrap at the top of the space.
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Reset pulse mid-stream.
    do_reset();
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      logic        rdy, rv;
      logic [31:0] rpc;
      if ($urandom_range(0, 399) == 0) do_reset();
      rdy = ($urandom_range(0, 3) != 0);
      if ((n / 40) % 3 == 2) rdy = ($urandom_range(0, 5) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? $urandom : (32'h0000_3000 + ($urandom & 32'hFFF));
      step(rdy, rv, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
